noise_generator_mc: RTL and testbench

//  Parametrised, multi-channel successor to the lab noise generator; one noise word per channel per enable.

---
 rtl/noise_generator_mc_pkg.sv | 17 +
 rtl/noise_generator_mc_if.sv | 22 ++
 rtl/noise_generator_mc_lfsr.sv | 29 ++
 rtl/noise_generator_mc.sv | 70 +++++++
 tb/tb_noise_generator_mc.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/noise_generator_mc_pkg.sv
// noise_gen_pkg: mode enum, LFSR constants and saturating-add helper shared by noise_generator_mc
package noise_gen_pkg;
  typedef enum logic [1:0] {MODE_OFF, MODE_SAW, MODE_LFSR, MODE_TPDF} noise_mode_e;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
  localparam logic [15:0] CH_SEED_STEP = 16'h9E37;
  function automatic logic [31:0] lfsr_taps(input int w);
    return w == 8 ? 32'hB8 : w == 24 ? 32'hE10000 : w == 32 ? 32'hA3000000 : 32'(LFSR_TAPS_16);
  endfunction
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a, input logic signed [63:0] b, input int w);
    logic signed [63:0] s, hi, lo;
    s = a + b;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    return s > hi ? hi : s < lo ? lo : s;
  endfunction
endpackage

// File: rtl/noise_generator_mc_if.sv
// noise_generator_mc_if: control/data bundle between the CODEC glue and noise_generator_mc (sample_in only with NOISE_SAT_ADD_EN)
interface noise_generator_mc_if import noise_gen_pkg::*; #(
  parameter int DATA_W = 24,
  parameter int NUM_CH = 2,
  parameter int LFSR_W = 16
);
  logic                       enable;
  noise_mode_e                mode;
  logic [$clog2(DATA_W)-1:0]  amp;
  logic                       seed_load;
  logic [LFSR_W-1:0]          seed;
  logic [NUM_CH*DATA_W-1:0]   Q;
  logic                       q_valid;
`ifdef NOISE_SAT_ADD_EN
  logic [NUM_CH*DATA_W-1:0]   sample_in;
  modport master(output enable, mode, amp, seed_load, seed, sample_in, input Q, q_valid);
  modport slave(input enable, mode, amp, seed_load, seed, sample_in, output Q, q_valid);
`else
  modport master(output enable, mode, amp, seed_load, seed, input Q, q_valid);
  modport slave(input enable, mode, amp, seed_load, seed, output Q, q_valid);
`endif
endinterface

// File: rtl/noise_generator_mc_lfsr.sv
// noise_lfsr: one Galois LFSR channel with per-channel seed offset, seed load and all-zero guard
module noise_lfsr import noise_gen_pkg::*; #(
  parameter int W = 16,
  parameter int RAW_W = 8,
  parameter logic [W-1:0] TAPS = W'(LFSR_TAPS_16),
  parameter logic [W-1:0] OFFSET = '0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             step_i,
  input  logic             load_i,
  input  logic [W-1:0]     seed_i,
  output logic [RAW_W-1:0] raw_o
);
  localparam logic [W-1:0] DEF = W'(DEFAULT_SEED);
  localparam logic [W-1:0] RST = (DEF ^ OFFSET) == '0 ? DEF : DEF ^ OFFSET;
  logic [W-1:0] state_q, state_d, next_s, load_v;
  // load beats step; a zero load falls back to the default seed so the register never locks up
  always_comb begin
    next_s = state_q[0] ? (state_q >> 1) ^ TAPS : state_q >> 1;
    load_v = seed_i ^ OFFSET;
    state_d = load_i ? (load_v == '0 ? DEF : load_v) : step_i ? next_s : state_q;
    raw_o = next_s[W-1 -: RAW_W];
  end
  // state register
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state_q <= RST;
    else state_q <= state_d;
endmodule

// File: rtl/noise_generator_mc.sv
// noise_generator_mc: multi-channel OFF/SAW/LFSR/TPDF noise source strobed by the CODEC enable
// Define NOISE_SAT_ADD_EN to add the noise onto bus.sample_in with saturation instead of emitting bare noise.
module noise_generator_mc import noise_gen_pkg::*; #(
  parameter int DATA_W = 24,
  parameter int NUM_CH = 2,
  parameter int NOISE_W = 8,
  parameter int LFSR_W = 16
) (
  input logic clk,
  input logic reset_n,
  noise_generator_mc_if.slave bus
);
  localparam int AMP_W = $clog2(DATA_W);
  localparam logic [AMP_W-1:0] MAX_SH = AMP_W'(DATA_W - NOISE_W);
  logic               step;
  logic [AMP_W-1:0]   sh;
  logic [NOISE_W-1:0] cnt_q, cnt_d;
  logic               valid_q;
  // a seed load pre-empts the step; the shift is clamped so the noise MSB always lands inside the word
  always_comb begin
    step = bus.enable & ~bus.seed_load;
    sh = bus.amp > MAX_SH ? MAX_SH : bus.amp;
    cnt_d = cnt_q + NOISE_W'(1);
  end
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [NOISE_W-1:0] raw, prev_q, n;
    logic [NOISE_W:0]   tp;
    logic [DATA_W-1:0]  placed, q_q, q_d;
    noise_lfsr #(
      .W(LFSR_W), .RAW_W(NOISE_W),
      .TAPS(LFSR_W'(lfsr_taps(LFSR_W))),
      .OFFSET(LFSR_W'(c * int'(CH_SEED_STEP)))
    ) u_lfsr (
      .clk(clk), .reset_n(reset_n), .step_i(step), .load_i(bus.seed_load),
      .seed_i(bus.seed), .raw_o(raw)
    );
    // mode mux on the post-step state, then sign-extend and place at the clamped shift
    always_comb begin
      tp = {raw[NOISE_W-1], raw} + {prev_q[NOISE_W-1], prev_q};
      n = bus.mode == MODE_SAW ? cnt_d : bus.mode == MODE_LFSR ? raw : bus.mode == MODE_TPDF ? NOISE_W'(tp >> 1) : '0;
      placed = {{(DATA_W-NOISE_W){n[NOISE_W-1]}}, n} << sh;
`ifdef NOISE_SAT_ADD_EN
      q_d = DATA_W'(sat_add(64'(signed'(bus.sample_in[c*DATA_W +: DATA_W])), 64'(signed'(placed)), DATA_W));
`else
      q_d = placed;
`endif
    end
    // TPDF history and output word advance only on an enable that is not pre-empted by a seed load
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) begin
        prev_q <= '0;
        q_q <= '0;
      end else if (bus.seed_load) prev_q <= '0;
      else if (bus.enable) begin
        prev_q <= raw;
        q_q <= q_d;
      end
    assign bus.Q[c*DATA_W +: DATA_W] = q_q;
  end
  // shared sawtooth counter and one-cycle valid strobe
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      cnt_q <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= step;
      cnt_q <= bus.seed_load ? '0 : bus.enable ? cnt_d : cnt_q;
    end
  assign bus.q_valid = valid_q;
endmodule

// File: tb/tb_noise_generator_mc.sv
// tb_noise_generator_mc: directed and randomized checks of noise_generator_mc against a behavioural model
module tb_noise_generator_mc;
  import noise_gen_pkg::*;
  localparam int DATA_W = 24, NUM_CH = 2, NOISE_W = 8, LFSR_W = 16;
  logic clk = 0, reset_n = 0;
  int checks = 0, errors = 0;
  int m_lfsr[NUM_CH], m_prev[NUM_CH], m_cnt;
  logic [DATA_W-1:0] m_q[NUM_CH];
  logic m_v;
  logic [NUM_CH*DATA_W-1:0] held;

  always #10 clk = ~clk;

  noise_generator_mc_if #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .LFSR_W(LFSR_W)) bus();
  noise_generator_mc #(.DATA_W(DATA_W), .NUM_CH(NUM_CH), .NOISE_W(NOISE_W), .LFSR_W(LFSR_W)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus));

  function automatic int guard(int v);
    return (v & 'hFFFF) == 0 ? 'hACE1 : (v & 'hFFFF);
  endfunction
  function automatic int sx8(int v);
    return v >= 128 ? v - 256 : v;
  endfunction
  function automatic logic [NUM_CH*DATA_W-1:0] exp_q();
    logic [NUM_CH*DATA_W-1:0] r;
    for (int c = 0; c < NUM_CH; c++) r[c*DATA_W +: DATA_W] = m_q[c];
    return r;
  endfunction

  task automatic m_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      m_lfsr[c] = guard('hACE1 ^ (c * 'h9E37));
      m_prev[c] = 0;
      m_q[c] = '0;
    end
    m_cnt = 0;
    m_v = 0;
  endtask

  task automatic set_in(input int md, input int a);
    bus.mode = noise_mode_e'(2'(md));
    bus.amp = 5'(a);
  endtask

  task automatic tick(input bit en, input bit sl);
    int n, raw, sh, s;
    bus.enable = en;
    bus.seed_load = sl;
    @(posedge clk);
    m_v = en && !sl;
    if (sl) begin
      m_cnt = 0;
      for (int c = 0; c < NUM_CH; c++) begin
        m_lfsr[c] = guard(int'(bus.seed) ^ (c * 'h9E37));
        m_prev[c] = 0;
      end
    end else if (en) begin
      m_cnt = (m_cnt + 1) % 256;
      sh = int'(bus.amp) > DATA_W - NOISE_W ? DATA_W - NOISE_W : int'(bus.amp);
      for (int c = 0; c < NUM_CH; c++) begin
        m_lfsr[c] = (m_lfsr[c] % 2 == 1) ? ((m_lfsr[c] / 2) ^ 'hB400) : m_lfsr[c] / 2;
        raw = sx8(m_lfsr[c] / 256);
        case (int'(bus.mode))
          1: n = sx8(m_cnt);
          2: n = raw;
          3: n = (raw + m_prev[c]) >>> 1;
          default: n = 0;
        endcase
        m_prev[c] = raw;
        n = n * (1 << sh);
`ifdef NOISE_SAT_ADD_EN
        s = int'(bus.sample_in[c*DATA_W +: DATA_W]);
        s = s >= (1 << 23) ? s - (1 << 24) : s;
        n = n + s;
        n = n > (1 << 23) - 1 ? (1 << 23) - 1 : n < -(1 << 23) ? -(1 << 23) : n;
`else
        s = 0;
        n = n + s;
`endif
        m_q[c] = DATA_W'(n);
      end
    end
    #1;
    bus.enable = 0;
    bus.seed_load = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    m_reset();
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.Q !== '0) begin errors++; $display("FAIL reset_q got %h exp 0", bus.Q); end
    checks++;
    if (bus.q_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", bus.q_valid); end
    @(negedge clk);
    reset_n = 1;
    m_reset();
  endtask

  task automatic test_lfsr();
    do_reset();
    set_in(2, 11);
    tick(1, 0);
    checks++;
    if (bus.Q[23:0] !== 24'hFF1000) begin errors++; $display("FAIL lfsr_first got %h exp ff1000", bus.Q[23:0]); end
    checks++;
    if (bus.Q !== exp_q() || bus.q_valid !== 1'b1) begin errors++; $display("FAIL lfsr_first_model got %h/%b exp %h/1", bus.Q, bus.q_valid, exp_q()); end
    tick(0, 0);
    checks++;
    if (bus.q_valid !== 1'b0 || bus.Q !== exp_q()) begin errors++; $display("FAIL lfsr_hold got %h/%b exp %h/0", bus.Q, bus.q_valid, exp_q()); end
    tick(1, 0);
    checks++;
    if (bus.Q[23:0] !== 24'h038800) begin errors++; $display("FAIL lfsr_second got %h exp 038800", bus.Q[23:0]); end
  endtask

  task automatic test_tpdf();
    do_reset();
    set_in(3, 0);
    tick(1, 0);
    checks++;
    if (bus.Q[23:0] !== 24'hFFFFF1 || bus.Q !== exp_q()) begin errors++; $display("FAIL tpdf_first got %h exp fffff1 / %h", bus.Q, exp_q()); end
    tick(1, 0);
    checks++;
    if (bus.Q[23:0] !== 24'h000029 || bus.Q !== exp_q()) begin errors++; $display("FAIL tpdf_second got %h exp 000029 / %h", bus.Q, exp_q()); end
  endtask

  task automatic test_seed();
    bus.seed = '0;
    held = bus.Q;
    tick(0, 1);
    checks++;
    if (bus.q_valid !== 1'b0 || bus.Q !== held) begin errors++; $display("FAIL seed_load_hold got %h/%b exp %h/0", bus.Q, bus.q_valid, held); end
    set_in(2, 11);
    tick(1, 0);
    checks++;
    if (bus.Q[23:0] !== 24'hFF1000) begin errors++; $display("FAIL seed_zero_guard got %h exp ff1000", bus.Q[23:0]); end
    held = bus.Q;
    tick(1, 1);
    checks++;
    if (bus.q_valid !== 1'b0 || bus.Q !== held) begin errors++; $display("FAIL seed_wins got %h/%b exp %h/0", bus.Q, bus.q_valid, held); end
    tick(1, 0);
    checks++;
    if (bus.Q[23:0] !== 24'hFF1000 || bus.q_valid !== 1'b1) begin errors++; $display("FAIL seed_no_step got %h/%b exp ff1000/1", bus.Q[23:0], bus.q_valid); end
  endtask

  task automatic test_amp_clamp();
    bus.seed = '0;
    tick(0, 1);
    set_in(2, 23);
    tick(1, 0);
    checks++;
    if (bus.Q[23:0] !== 24'hE20000 || bus.Q !== exp_q()) begin errors++; $display("FAIL amp_clamp23 got %h exp e20000 / %h", bus.Q, exp_q()); end
    tick(0, 1);
    set_in(2, 31);
    tick(1, 0);
    checks++;
    if (bus.Q[23:0] !== 24'hE20000) begin errors++; $display("FAIL amp_clamp31 got %h exp e20000", bus.Q[23:0]); end
    held = bus.Q;
    set_in(3, 0);
    tick(0, 0);
    checks++;
    if (bus.Q !== held) begin errors++; $display("FAIL no_glitch got %h exp %h", bus.Q, held); end
  endtask

  task automatic test_saw();
    tick(0, 1);
    set_in(1, 11);
    for (int i = 1; i <= 256; i++) begin
      tick(1, 0);
      if (i == 5) begin
        checks++;
        if (bus.Q !== {24'h002800, 24'h002800}) begin errors++; $display("FAIL saw_five got %h exp 002800002800", bus.Q); end
      end
      if (i == 255) begin
        checks++;
        if (bus.Q[23:0] !== 24'hFFF800) begin errors++; $display("FAIL saw_top got %h exp fff800", bus.Q[23:0]); end
      end
      checks++;
      if (bus.Q !== exp_q()) begin errors++; $display("FAIL saw_step%0d got %h exp %h", i, bus.Q, exp_q()); end
    end
    checks++;
    if (bus.Q !== '0) begin errors++; $display("FAIL saw_wrap got %h exp 0", bus.Q); end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      set_in($urandom_range(0, 3), $urandom_range(0, 31));
      bus.seed = ($urandom_range(0, 7) == 0) ? '0 : 16'($urandom);
`ifdef NOISE_SAT_ADD_EN
      bus.sample_in = {24'($urandom), 24'($urandom)};
`endif
      tick($urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
      checks++;
      if (bus.Q !== exp_q() || bus.q_valid !== m_v) begin errors++; $display("FAIL random%0d got %h/%b exp %h/%b", i, bus.Q, bus.q_valid, exp_q(), m_v); end
    end
  endtask

  task automatic test_reset_mid();
    set_in(2, 11);
    repeat (3) tick(1, 0);
    #3;
    reset_n = 0;
    #1;
    checks++;
    if (bus.Q !== '0 || bus.q_valid !== 1'b0) begin errors++; $display("FAIL reset_mid got %h/%b exp 0/0", bus.Q, bus.q_valid); end
    @(negedge clk);
    reset_n = 1;
    m_reset();
    tick(1, 0);
    checks++;
    if (bus.Q[23:0] !== 24'hFF1000 || bus.Q !== exp_q()) begin errors++; $display("FAIL reset_mid_restart got %h exp ff1000 / %h", bus.Q, exp_q()); end
  endtask

  initial begin
    bus.enable = 0;
    bus.seed_load = 0;
    bus.seed = '0;
    set_in(0, 0);
`ifdef NOISE_SAT_ADD_EN
    bus.sample_in = '0;
`endif
    test_reset();
    test_lfsr();
    test_tpdf();
    test_seed();
    test_amp_clamp();
    test_saw();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
